mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, meaning: log2 of the number of 16-bit words in the array (256 words).
REQ-002 Parameter WAIT_CYC, default 2, meaning: number of access wait cycles between request acceptance and completion; legal range 0..15.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 mem_en  input  1  access request level from the controller FSMs; held high until mfc is seen.
REQ-006 rw  input  1  access type, sampled with the request: 1 = read, 0 = write.
REQ-007 addr  input  16  word address from the MAR.
REQ-008 data_in  input  16  write data from the MDR write register.
REQ-009 data_out  output  16  read data to the MDR read register; registered.
REQ-010 mfc  output  1  memory-function-complete, a one-cycle pulse.
REQ-011 busy  output  1  high while a request is in flight (WAIT or DONE state).
REQ-012 addr_err  output  1  pulses with mfc when the latched address is out of range.
REQ-013 ld_en  input  1  preload write strobe for program loading.
REQ-014 ld_addr  input  16  preload word address.
REQ-015 ld_data  input  16  preload data.

Function
REQ-016 The FSM SHALL have four states: IDLE, WAIT, DONE and RELEASE.
REQ-017 IDLE: when mem_en=1, latch addr, data_in and rw, load the wait counter with WAIT_CYC, and go to WAIT; if WAIT_CYC=0, go directly to DONE.
REQ-018 WAIT: decrement the counter each cycle; when the counter reaches 1, go to DONE. Total latency from the acceptance edge to mfc high is WAIT_CYC+1 cycles.
REQ-019 DONE (lasting one cycle): assert mfc=1; commit a write to the array; for a read, update data_out from the array in the same cycle that mfc rises. Then go to RELEASE.
REQ-020 RELEASE: stay until mem_en=0, then go to IDLE. mem_en held high SHALL never trigger a second access.
REQ-021 The address is in range when addr[15:DEPTH_LOG2]==0. Out-of-range write: no array update. Out-of-range read: data_out=16'h0000. In both cases addr_err=1 with mfc.
REQ-022 data_out SHALL hold its last read value through writes, idle periods and out-of-range writes.
REQ-023 Changes to addr, data_in or rw after acceptance SHALL have no effect on the access in flight.
REQ-024 The ld_en write SHALL be honoured only in IDLE with mem_en=0; otherwise it is ignored. An out-of-range ld_addr is ignored silently.
REQ-025 If ld_en and mem_en are both high in IDLE, the request wins and the preload is dropped.
REQ-026 busy=1 in WAIT and DONE; busy=0 in IDLE and RELEASE.

Reset
REQ-027 rst=1 SHALL force IDLE, the counter to 0, mfc=0, addr_err=0, busy=0 and data_out=16'h0000 on the next edge.
REQ-028 Reset during WAIT SHALL abort the access: no write is committed and no mfc is produced.
REQ-029 Array contents are not cleared by reset.

Structure
REQ-030 The state encoding and the RW_READ/RW_WRITE constants SHALL live in a shared package used by mem_ctrl and the controller FSMs.
REQ-031 The storage SHALL be a sub-module mem_array: one synchronous write port and one read port, registered by mem_ctrl.

Verification
REQ-032 Preload 16'hBEEF at address 5 via ld_en, then read address 5 with WAIT_CYC=2 -> mfc high exactly 3 cycles after acceptance, data_out=16'hBEEF.
REQ-033 Write 16'h1234 to address 10, change data_in to 16'h0000 one cycle after acceptance, then read address 10 -> data_out=16'h1234.
REQ-034 Read address 16'h0100 (out of range, DEPTH_LOG2=8) -> mfc=1 and addr_err=1 in the same cycle, data_out=16'h0000.
REQ-035 Hold mem_en high for 6 cycles after mfc -> exactly one mfc pulse; a new request is accepted only after mem_en drops for at least one cycle.
REQ-036 Start a write of 16'hAAAA to address 3, assert rst during WAIT, then read address 3 -> previous contents returned, no mfc during the aborted access.
REQ-037 Assert ld_en and mem_en together in IDLE (rw=1) -> the read completes and the preload target address is unchanged.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller and the controller FSMs that drive it.
// Holds the access-FSM state encoding, the rw polarity constants and the address range check.
// No logic of its own; latency and backpressure are defined by the users.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } mem_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // An address is in range when every bit above the array index is zero.
  function automatic logic addr_in_range(input logic [15:0] a, input int depth_log2);
    return (a >> depth_log2) == 16'h0000;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus between a controller FSM (master) and mem_ctrl (slave), plus the program preload port.
// Pure wiring, no latency.
// Master holds mem_en until mfc; the slave ignores a held mem_en after completion.
interface mem_ctrl_if;
  logic        mem_en;
  logic        rw;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        mfc;
  logic        busy;
  logic        addr_err;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  modport master (
    output mem_en, rw, addr, data_in, ld_en, ld_addr, ld_data,
    input  data_out, mfc, busy, addr_err
  );

  modport slave (
    input  mem_en, rw, addr, data_in, ld_en, ld_addr, ld_data,
    output data_out, mfc, busy, addr_err
  );
endinterface

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Write lands on the clock edge; read data is valid in the same cycle as raddr.
// No backpressure; the owner registers the read data.
module mem_array #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Synchronous write; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_ctrl.sv
// Handshaked single-port memory controller with fixed wait states and a preload port.
// Latency: mfc pulses WAIT_CYC+1 cycles after the edge that accepts mem_en.
// A held mem_en is parked in RELEASE until it drops; preload is only taken when idle and unrequested.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int WAIT_CYC   = 2
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  mem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;

  logic [15:0] lat_addr;
  logic [15:0] lat_data;
  logic        lat_rw;
  logic        lat_ok;

  logic        mfc_q;
  logic        err_q;
  logic [15:0] dout_q;

  logic        do_write;
  logic        do_load;
  logic        arr_we;
  logic [DEPTH_LOG2-1:0] arr_waddr;
  logic [15:0] arr_wdata;
  logic [15:0] arr_rdata;

  assign lat_ok = addr_in_range(lat_addr, DEPTH_LOG2);

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept, count down the wait states, complete, then wait for mem_en to drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_en) begin
          accept  = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYC == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = DONE;
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.mem_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request at acceptance so later bus changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr <= 16'h0000;
      lat_data <= 16'h0000;
      lat_rw   <= RW_READ;
    end else if (accept) begin
      lat_addr <= bus.addr;
      lat_data <= bus.data_in;
      lat_rw   <= bus.rw;
    end
  end

  // Completion outputs: mfc/addr_err pulse and read data all update on the edge leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mfc_q  <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= 16'h0000;
    end else begin
      mfc_q <= (state_q == DONE);
      err_q <= (state_q == DONE) && !lat_ok;
      if (state_q == DONE && lat_rw == RW_READ) begin
        dout_q <= lat_ok ? arr_rdata : 16'h0000;
      end
    end
  end

  // Access writes and preloads never coincide: one needs DONE, the other IDLE.
  assign do_write  = !rst && (state_q == DONE) && (lat_rw == RW_WRITE) && lat_ok;
  assign do_load   = !rst && (state_q == IDLE) && !bus.mem_en && bus.ld_en
                     && addr_in_range(bus.ld_addr, DEPTH_LOG2);
  assign arr_we    = do_write || do_load;
  assign arr_waddr = do_write ? lat_addr[DEPTH_LOG2-1:0] : bus.ld_addr[DEPTH_LOG2-1:0];
  assign arr_wdata = do_write ? lat_data : bus.ld_data;

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (16)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .raddr(lat_addr[DEPTH_LOG2-1:0]),
    .rdata(arr_rdata)
  );

  assign bus.mfc      = mfc_q;
  assign bus.addr_err = err_q;
  assign bus.data_out = dout_q;
  assign bus.busy     = (state_q == WAIT) || (state_q == DONE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of accesses plus hand-written corner sequences.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Every wait for mfc is bounded by a cycle budget.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_ctrl_if bus();

  mem_ctrl #(
    .DEPTH_LOG2(8),
    .WAIT_CYC  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for mfc after the acceptance edge; lat is the number of edges counted, 0 on timeout.
  task automatic wait_mfc(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.mfc) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_access(input logic r, input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] dout, output logic err, output int lat);
    bus.mem_en  = 1'b1;
    bus.rw      = r;
    bus.addr    = a;
    bus.data_in = d;
    step();
    wait_mfc(lat);
    dout = bus.data_out;
    err  = bus.addr_err;
    bus.mem_en = 1'b0;
    step();
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    step();
    bus.ld_en = 1'b0;
  endtask

  initial begin
    logic [15:0] dout;
    logic        err;
    int          lat;
    int          extra_mfc;
    int          busy_seen;
    int          mfc_seen;

    checks = 0;
    errors = 0;
    bus.mem_en  = 1'b0;
    bus.rw      = 1'b1;
    bus.addr    = 16'h0000;
    bus.data_in = 16'h0000;
    bus.ld_en   = 1'b0;
    bus.ld_addr = 16'h0000;
    bus.ld_data = 16'h0000;

    vecs[0]  = '{1'b1, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};
    vecs[1]  = '{1'b0, 16'h000A, 16'h0F0F, 16'hBEEF, 1'b0};
    vecs[2]  = '{1'b1, 16'h000A, 16'h0000, 16'h0F0F, 1'b0};
    vecs[3]  = '{1'b1, 16'h0100, 16'h0000, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 16'h0200, 16'hABCD, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 16'h00FF, 16'h7777, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 16'h00FF, 16'h0000, 16'h7777, 1'b0};
    vecs[7]  = '{1'b1, 16'h0003, 16'h0000, 16'h5555, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0001, 16'h5555, 1'b0};
    vecs[9]  = '{1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0};
    vecs[10] = '{1'b1, 16'h8005, 16'h0000, 16'h0000, 1'b1};
    vecs[11] = '{1'b1, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};

    // Reset state.
    rst = 1'b1;
    step();
    step();
    check("rst_data_out", bus.data_out, 16'h0000);
    check("rst_mfc", {15'd0, bus.mfc}, 16'd0);
    check("rst_busy", {15'd0, bus.busy}, 16'd0);
    check("rst_addr_err", {15'd0, bus.addr_err}, 16'd0);
    rst = 1'b0;
    step();

    // Program preload; the out-of-range one must not alias onto word 5.
    preload(16'h0005, 16'hBEEF);
    preload(16'h0003, 16'h5555);
    preload(16'h0007, 16'h0707);
    preload(16'h0105, 16'h1111);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      do_access(vecs[i].rw, vecs[i].addr, vecs[i].din, dout, err, lat);
      check($sformatf("vec%0d_latency", i), 16'(lat), 16'd3);
      check($sformatf("vec%0d_data_out", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_addr_err", i), {15'd0, err}, {15'd0, vecs[i].exp_err});
    end

    // Write data/address/rw changed after acceptance must not affect the access.
    bus.mem_en  = 1'b1;
    bus.rw      = 1'b0;
    bus.addr    = 16'h000A;
    bus.data_in = 16'h1234;
    step();
    check("wait_busy", {15'd0, bus.busy}, 16'd1);
    bus.data_in = 16'h0000;
    bus.addr    = 16'h000B;
    bus.rw      = 1'b1;
    wait_mfc(lat);
    check("late_change_latency", 16'(lat), 16'd3);
    bus.mem_en = 1'b0;
    step();
    do_access(1'b1, 16'h000A, 16'h0000, dout, err, lat);
    check("late_change_readback", dout, 16'h1234);

    // mem_en held after mfc: one pulse only, new access needs a low cycle.
    bus.mem_en = 1'b1;
    bus.rw     = 1'b1;
    bus.addr   = 16'h0005;
    step();
    wait_mfc(lat);
    check("held_first_latency", 16'(lat), 16'd3);
    extra_mfc = 0;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.mfc) extra_mfc++;
      if (bus.busy) busy_seen++;
    end
    check("held_extra_mfc", 16'(extra_mfc), 16'd0);
    check("held_busy", 16'(busy_seen), 16'd0);
    bus.mem_en = 1'b0;
    step();
    bus.mem_en = 1'b1;
    step();
    check("reaccept_busy", {15'd0, bus.busy}, 16'd1);
    wait_mfc(lat);
    check("reaccept_latency", 16'(lat), 16'd3);
    bus.mem_en = 1'b0;
    step();

    // Reset during WAIT aborts the write with no mfc.
    mfc_seen = 0;
    bus.mem_en  = 1'b1;
    bus.rw      = 1'b0;
    bus.addr    = 16'h0003;
    bus.data_in = 16'hAAAA;
    step();
    if (bus.mfc) mfc_seen++;
    step();
    if (bus.mfc) mfc_seen++;
    rst = 1'b1;
    bus.mem_en = 1'b0;
    step();
    if (bus.mfc) mfc_seen++;
    check("abort_data_out", bus.data_out, 16'h0000);
    check("abort_busy", {15'd0, bus.busy}, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.mfc) mfc_seen++;
    end
    check("abort_no_mfc", 16'(mfc_seen), 16'd0);
    do_access(1'b1, 16'h0003, 16'h0000, dout, err, lat);
    check("abort_readback", dout, 16'h5555);
    check("abort_readback_latency", 16'(lat), 16'd3);

    // Request and preload together in IDLE: the read wins, preload dropped.
    bus.ld_en   = 1'b1;
    bus.ld_addr = 16'h0005;
    bus.ld_data = 16'h0000;
    bus.mem_en  = 1'b1;
    bus.rw      = 1'b1;
    bus.addr    = 16'h0007;
    step();
    bus.ld_en = 1'b0;
    wait_mfc(lat);
    check("collide_latency", 16'(lat), 16'd3);
    check("collide_data_out", bus.data_out, 16'h0707);
    bus.mem_en = 1'b0;
    step();
    do_access(1'b1, 16'h0005, 16'h0000, dout, err, lat);
    check("collide_target_kept", dout, 16'hBEEF);

    // Preload strobed while an access is in flight is ignored.
    bus.mem_en = 1'b1;
    bus.rw     = 1'b1;
    bus.addr   = 16'h0000;
    step();
    preload(16'h0003, 16'hDEAD);
    wait_mfc(lat);
    check("busy_preload_latency", 16'(lat), 16'd2);
    bus.mem_en = 1'b0;
    step();
    do_access(1'b1, 16'h0003, 16'h0000, dout, err, lat);
    check("busy_preload_ignored", dout, 16'h5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
